// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types and the memory-stage state encoding.
package cpu_types_pkg;
   localparam int WORD_BITS = 32;
   localparam int REG_BITS = 5;
   typedef logic [WORD_BITS-1:0] word_t;
   typedef logic [REG_BITS-1:0] regbits_t;
   typedef enum logic [1:0] {IDLE, WAIT, HALTED} memstage_state_t;
   typedef struct packed {
      word_t npc;
      word_t rdat;
      word_t result;
      regbits_t reg_dest;
      logic reg_wen;
      logic pc2reg;
      logic mem2reg;
   } mem_wb_t;
endpackage

// File: rtl/mem_wb_latch.sv
// mem_wb_latch: MEM/WB output flops with load/bubble control and a sticky halt bit.
module mem_wb_latch
   import cpu_types_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    load,
   input  logic    bubble,
   input  logic    halt_set,
   input  mem_wb_t fields,
   output mem_wb_t out,
   output logic    halt
);
   mem_wb_t out_d, out_q;
   logic halt_d, halt_q;
   always_comb begin
      out_d = load ? fields : bubble ? '0 : out_q;
      halt_d = halt_q | halt_set;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
         halt_q <= 1'b0;
      end else begin
         out_q <= out_d;
         halt_q <= halt_d;
      end
   end
   assign out = out_q;
   assign halt = halt_q;
endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: issues D-cache requests, stalls until dhit, and feeds the MEM/WB latch.
module memory_access_stage
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int REG_W = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_npc,
   input  logic [WORD_W-1:0] in_result,
   input  logic [WORD_W-1:0] in_store,
   input  logic [REG_W-1:0]  in_RegDest,
   input  logic              in_RegWen,
   input  logic              in_pc2reg,
   input  logic              in_mem2reg,
   input  logic              in_dREN,
   input  logic              in_dWEN,
   input  logic              in_halt,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [WORD_W-1:0] dmemaddr,
   output logic [WORD_W-1:0] dmemstore,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dmemload,
   output logic              stall,
   output logic [WORD_W-1:0] MEM_npc_OUT,
   output logic [WORD_W-1:0] MEM_rdat_OUT,
   output logic [WORD_W-1:0] MEM_result_OUT,
   output logic [REG_W-1:0]  MEM_RegDest_OUT,
   output logic              MEM_RegWen_OUT,
   output logic              MEM_pc2reg_OUT,
   output logic              MEM_mem2reg_OUT,
   output logic              MEM_halt_OUT
);
   memstage_state_t state_d, state_q;
   logic mem_op, active, load, halt_set;
   mem_wb_t fields, out;
   always_comb begin
      mem_op = in_valid & (in_dREN | in_dWEN);
      active = (state_q != HALTED) & mem_op;
      // write wins when both strobes are requested
      dmemWEN = active & in_dWEN;
      dmemREN = active & in_dREN & ~in_dWEN;
      dmemaddr = active ? in_result : '0;
      dmemstore = active ? in_store : '0;
      stall = active & ~dhit;
      load = (state_q != HALTED) & in_valid & ~stall;
      halt_set = (state_q == IDLE) & in_valid & in_halt & ~mem_op;
      fields.npc = in_npc;
      fields.rdat = mem_op ? (((state_q == WAIT) & in_dWEN) ? '0 : dmemload) : '0;
      fields.result = in_result;
      fields.reg_dest = in_RegDest;
      fields.reg_wen = in_RegWen;
      fields.pc2reg = in_pc2reg;
      fields.mem2reg = in_mem2reg;
      state_d = (state_q == HALTED || halt_set) ? HALTED : stall ? WAIT : IDLE;
   end
   always_ff @(posedge CLK) begin
      if (RST) state_q <= IDLE;
      else state_q <= state_d;
   end
   mem_wb_latch u_latch (
      .clk     (CLK),
      .rst     (RST),
      .load    (load),
      .bubble  (~load),
      .halt_set(halt_set),
      .fields  (fields),
      .out     (out),
      .halt    (MEM_halt_OUT)
   );
   assign MEM_npc_OUT = out.npc;
   assign MEM_rdat_OUT = out.rdat;
   assign MEM_result_OUT = out.result;
   assign MEM_RegDest_OUT = out.reg_dest;
   assign MEM_RegWen_OUT = out.reg_wen;
   assign MEM_pc2reg_OUT = out.pc2reg;
   assign MEM_mem2reg_OUT = out.mem2reg;
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: directed-vector bench for the memory access stage.
module tb_memory_access_stage;
   logic CLK = 1'b0;
   logic RST;
   logic in_valid, in_RegWen, in_pc2reg, in_mem2reg, in_dREN, in_dWEN, in_halt, dhit;
   logic [31:0] in_npc, in_result, in_store, dmemload;
   logic [4:0] in_RegDest;
   logic dmemREN, dmemWEN, stall;
   logic [31:0] dmemaddr, dmemstore, MEM_npc_OUT, MEM_rdat_OUT, MEM_result_OUT;
   logic [4:0] MEM_RegDest_OUT;
   logic MEM_RegWen_OUT, MEM_pc2reg_OUT, MEM_mem2reg_OUT, MEM_halt_OUT;
   int checks = 0;
   int errors = 0;
   always #5 CLK = ~CLK;
   memory_access_stage dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_npc(in_npc), .in_result(in_result),
      .in_store(in_store), .in_RegDest(in_RegDest), .in_RegWen(in_RegWen), .in_pc2reg(in_pc2reg),
      .in_mem2reg(in_mem2reg), .in_dREN(in_dREN), .in_dWEN(in_dWEN), .in_halt(in_halt),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .dhit(dhit), .dmemload(dmemload), .stall(stall), .MEM_npc_OUT(MEM_npc_OUT),
      .MEM_rdat_OUT(MEM_rdat_OUT), .MEM_result_OUT(MEM_result_OUT),
      .MEM_RegDest_OUT(MEM_RegDest_OUT), .MEM_RegWen_OUT(MEM_RegWen_OUT),
      .MEM_pc2reg_OUT(MEM_pc2reg_OUT), .MEM_mem2reg_OUT(MEM_mem2reg_OUT),
      .MEM_halt_OUT(MEM_halt_OUT)
   );
   always @(posedge CLK)
      assert (!(in_valid && in_halt && (in_dREN || in_dWEN)));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic drive(input logic v, input logic [31:0] npc, input logic [31:0] res,
                        input logic [31:0] st, input logic [4:0] rd, input logic wen,
                        input logic p2r, input logic m2r, input logic ren, input logic wr,
                        input logic h);
      in_valid = v; in_npc = npc; in_result = res; in_store = st; in_RegDest = rd;
      in_RegWen = wen; in_pc2reg = p2r; in_mem2reg = m2r; in_dREN = ren; in_dWEN = wr;
      in_halt = h;
      #1;
   endtask
   task automatic chk_zero_out(input string tag);
      chk({tag, " npc"}, MEM_npc_OUT, 32'h0);
      chk({tag, " rdat"}, MEM_rdat_OUT, 32'h0);
      chk({tag, " result"}, MEM_result_OUT, 32'h0);
      chk({tag, " ctl"}, {27'h0, MEM_RegDest_OUT}, 32'h0);
      chk({tag, " flags"}, {28'h0, MEM_RegWen_OUT, MEM_pc2reg_OUT, MEM_mem2reg_OUT, MEM_halt_OUT}, 32'h0);
   endtask
   initial begin
      RST = 1'b1; dhit = 1'b0; dmemload = '0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      RST = 1'b0;
      #1;
      chk_zero_out("reset");
      chk("reset strobes", {29'h0, stall, dmemREN, dmemWEN}, 32'h0);
      chk("reset addr", dmemaddr, 32'h0);
      // same-cycle store hit
      dhit = 1'b1;
      drive(1, 32'h8, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 0, 0, 1, 0);
      chk("st WEN/REN", {30'h0, dmemWEN, dmemREN}, 32'h2);
      chk("st addr", dmemaddr, 32'h100);
      chk("st data", dmemstore, 32'hDEADBEEF);
      chk("st stall", {31'h0, stall}, 32'h0);
      tick();
      chk("st result", MEM_result_OUT, 32'h100);
      chk("st regwen", {31'h0, MEM_RegWen_OUT}, 32'h0);
      // delayed load: three stall cycles then a hit
      dhit = 1'b0;
      drive(1, 32'h44, 32'h40, 32'h0, 5'd5, 1, 0, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("ld stall %0d", i), {30'h0, stall, dmemREN}, 32'h3);
         chk($sformatf("ld addr %0d", i), dmemaddr, 32'h40);
         tick();
         chk($sformatf("ld bubble %0d", i), {MEM_result_OUT[30:0], MEM_RegWen_OUT}, 32'h0);
      end
      dhit = 1'b1; dmemload = 32'h12345678;
      #1;
      chk("ld hit stall", {30'h0, stall, dmemREN}, 32'h1);
      tick();
      chk("ld rdat", MEM_rdat_OUT, 32'h12345678);
      chk("ld flags", {28'h0, MEM_RegWen_OUT, MEM_pc2reg_OUT, MEM_mem2reg_OUT, MEM_halt_OUT}, 32'ha);
      chk("ld dest", {27'h0, MEM_RegDest_OUT}, 32'd5);
      chk("ld npc", MEM_npc_OUT, 32'h44);
      // ALU, ALU, load back to back
      dhit = 1'b0;
      drive(1, 32'h70, 32'h11, 32'h0, 5'd1, 1, 0, 0, 0, 0, 0);
      chk("alu1 stall", {31'h0, stall}, 32'h0);
      tick();
      chk("alu1 result", MEM_result_OUT, 32'h11);
      chk("alu1 rdat", MEM_rdat_OUT, 32'h0);
      drive(1, 32'h80, 32'h22, 32'h0, 5'd2, 1, 1, 0, 0, 0, 0);
      chk("alu2 strobes", {29'h0, stall, dmemREN, dmemWEN}, 32'h0);
      tick();
      chk("alu2 result", MEM_result_OUT, 32'h22);
      chk("alu2 flags", {28'h0, MEM_RegWen_OUT, MEM_pc2reg_OUT, MEM_mem2reg_OUT, MEM_halt_OUT}, 32'hc);
      chk("alu2 npc", MEM_npc_OUT, 32'h80);
      dhit = 1'b1; dmemload = 32'hCAFE0001;
      drive(1, 32'h84, 32'h30, 32'h0, 5'd3, 1, 0, 1, 1, 0, 0);
      chk("ld2 stall", {30'h0, stall, dmemREN}, 32'h1);
      tick();
      chk("ld2 rdat", MEM_rdat_OUT, 32'hCAFE0001);
      chk("ld2 result", MEM_result_OUT, 32'h30);
      dhit = 1'b0;
      drive(0, 32'h99, 32'h99, 32'h0, 5'd9, 1, 1, 1, 0, 0, 0);
      tick();
      chk_zero_out("bubble");
      // both strobes requested: write only
      dhit = 1'b1;
      drive(1, 32'h88, 32'h200, 32'h5A5A, 5'd4, 0, 0, 0, 1, 1, 0);
      chk("both strobes", {30'h0, dmemWEN, dmemREN}, 32'h2);
      tick();
      // reset during WAIT
      dhit = 1'b0;
      drive(1, 32'h8c, 32'h300, 32'h0, 5'd6, 1, 0, 1, 1, 0, 0);
      tick();
      tick();
      chk("rst pre stall", {31'h0, stall}, 32'h1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      dhit = 1'b1; dmemload = 32'hBADBAD00;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk_zero_out("rst");
      chk("rst strobes", {29'h0, stall, dmemREN, dmemWEN}, 32'h0);
      tick();
      chk_zero_out("rst late dhit");
      // after reset a load with no hit must stall from IDLE again
      dhit = 1'b0;
      drive(1, 32'h90, 32'h310, 32'h0, 5'd7, 1, 0, 1, 1, 0, 0);
      chk("rst idle ld", {30'h0, stall, dmemREN}, 32'h3);
      dhit = 1'b1; dmemload = 32'h0000BEEF;
      #1;
      tick();
      chk("rst idle rdat", MEM_rdat_OUT, 32'h0000BEEF);
      // halt then a load
      dhit = 1'b0;
      drive(1, 32'hA0, 32'h55, 32'h0, 5'd0, 0, 0, 0, 0, 0, 1);
      chk("halt stall", {31'h0, stall}, 32'h0);
      tick();
      chk("halt out", {31'h0, MEM_halt_OUT}, 32'h1);
      chk("halt npc", MEM_npc_OUT, 32'hA0);
      chk("halt result", MEM_result_OUT, 32'h55);
      drive(1, 32'hA4, 32'h60, 32'h0, 5'd8, 1, 0, 1, 1, 0, 0);
      chk("halted strobes", {29'h0, stall, dmemREN, dmemWEN}, 32'h0);
      tick();
      chk("halted flags", {28'h0, MEM_RegWen_OUT, MEM_pc2reg_OUT, MEM_mem2reg_OUT, MEM_halt_OUT}, 32'h1);
      chk("halted result", MEM_result_OUT, 32'h0);
      tick();
      chk("halt sticky", {30'h0, MEM_halt_OUT, dmemREN}, 32'h2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
